// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared state encoding and BCD constants for the seven-segment scan controller.
package seven_seg_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/seven_seg_scan_timer.sv
// scan_timer: loadable down-counter that flags expiry when it reaches zero.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         expire
);
    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else cnt <= load ? load_val : (cnt != '0) ? cnt - 1'b1 : cnt;
    end
    assign expire = cnt == '0;
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of a packed BCD value onto one shared decoder.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lz_blank_en,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done,
    output logic                    invalid_err
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    state_t                  state, state_nxt;
    logic [4*NUM_DIGITS-1:0] active, shadow, act_nxt;
    logic                    pending, supp, supp_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [CW-1:0]           cnt, tmr_val;
    logic                    expire, tmr_load, xfer, boundary, upd_active, enter_blank, frame_nxt;
    logic [3:0]              bcd_nxt;
    logic [NUM_DIGITS-1:0]   den_nxt;

    function automatic logic suppressed(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] i,
                                        input logic lz);
        logic hi_zero;
        hi_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(i) && v[4*j +: 4] != 4'd0) hi_zero = 1'b0;
        return v[{i, 2'b00} +: 4] > BCD_MAX || (lz && i != '0 && hi_zero);
    endfunction

    function automatic logic has_bad(input logic [4*NUM_DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (v[4*j +: 4] > BCD_MAX) bad = 1'b1;
        return bad;
    endfunction

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (cnt),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = xfer ? BLANK : IDLE;
        else if (expire) state_nxt = (state == BLANK) ? DRIVE : BLANK;
    end

    // Everything below is the next value of a registered output, so no input reaches a pin combinationally.
    always_comb begin
        xfer        = load_valid && !pending;
        boundary    = state == DRIVE && expire && idx == LAST;
        upd_active  = (state == IDLE && xfer) || (boundary && (pending || xfer));
        act_nxt     = !upd_active ? active : pending ? shadow : load_value;
        enter_blank = (state == IDLE && xfer) || (state == DRIVE && expire);
        idx_nxt     = (state == IDLE) ? '0 : (state == DRIVE && expire) ? (idx == LAST ? '0 : idx + 1'b1) : idx;
        tmr_load    = enter_blank || (state == BLANK && expire);
        tmr_val     = enter_blank ? CW'(BLANK_CYCLES - 1) : CW'(DWELL_CYCLES - 1);
        supp_nxt    = enter_blank ? suppressed(act_nxt, idx_nxt, lz_blank_en) : supp;
        bcd_nxt     = !enter_blank ? bcd : supp_nxt ? BCD_BLANK : act_nxt[{idx_nxt, 2'b00} +: 4];
        den_nxt     = (state_nxt == DRIVE && !supp) ? NUM_DIGITS'(1) << idx : '0;
        frame_nxt   = idx == LAST && ((state == DRIVE && cnt == CW'(1)) ||
                                      (state == BLANK && expire && DWELL_CYCLES == 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            idx         <= '0;
            supp        <= 1'b0;
            bcd         <= '0;
            digit_en    <= '0;
            frame_done  <= 1'b0;
            invalid_err <= 1'b0;
        end else begin
            active     <= act_nxt;
            idx        <= idx_nxt;
            supp       <= supp_nxt;
            bcd        <= bcd_nxt;
            digit_en   <= den_nxt;
            frame_done <= frame_nxt;
            if (upd_active) invalid_err <= has_bad(act_nxt);
            if (boundary) begin
                pending <= 1'b0;
            end else if (xfer && state != IDLE) begin
                shadow  <= load_value;
                pending <= 1'b1;
            end
        end
    end

    assign load_ready = !pending;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and randomized checks against a frame-position model.
module tb_seven_seg_scan_ctrl;
    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;
    localparam int P = B + D;
    localparam int FRAME = N * P;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [4*N-1:0] load_value = '0;
    logic          lz_blank_en = 1'b0;
    logic [3:0]    bcd;
    logic [N-1:0]  digit_en;
    logic          frame_done;
    logic          invalid_err;

    int errs = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    bit             m_run = 1'b0, m_pend = 1'b0, m_inv = 1'b0, m_supp = 1'b0;
    int             m_p = 0;
    logic [4*N-1:0] m_act = '0, m_sh = '0;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .lz_blank_en (lz_blank_en),
        .bcd         (bcd),
        .digit_en    (digit_en),
        .frame_done  (frame_done),
        .invalid_err (invalid_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nib(input logic [4*N-1:0] v, input int i);
        return int'((v >> (4 * i)) & 16'hF);
    endfunction

    function automatic bit bad_any(input logic [4*N-1:0] v);
        for (int i = 0; i < N; i++) if (nib(v, i) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit dark(input logic [4*N-1:0] v, input int i, input bit lz);
        return nib(v, i) > 9 || (lz && i != 0 && (v >> (4 * i)) == 0);
    endfunction

    function automatic logic [4*N-1:0] rand_val();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++)
            v[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        return v;
    endfunction

    // Model: position within the frame since the first load; the active value swaps only at the wrap.
    initial forever begin
        bit xf;
        @(posedge clk);
        if (!reset) begin
            m_run = 1'b0;
            m_pend = 1'b0;
            m_inv = 1'b0;
            m_p = 0;
        end else begin
            xf = load_valid && !m_pend;
            if (!m_run) begin
                if (xf) begin
                    m_run = 1'b1;
                    m_p = 0;
                    m_act = load_value;
                    m_inv = bad_any(m_act);
                    m_supp = dark(m_act, 0, lz_blank_en);
                end
            end else begin
                if (m_p == FRAME - 1) begin
                    if (m_pend || xf) begin
                        m_act = m_pend ? m_sh : load_value;
                        m_inv = bad_any(m_act);
                    end
                    m_pend = 1'b0;
                end else if (xf) begin
                    m_sh = load_value;
                    m_pend = 1'b1;
                end
                m_p = (m_p + 1) % FRAME;
                if (m_p % P == 0) m_supp = dark(m_act, m_p / P, lz_blank_en);
            end
        end
    end

    initial forever begin
        int dg;
        @(negedge clk);
        if (cmp_en) begin
            dg = m_p / P;
            chk("m_bcd", bcd, !m_run ? 0 : m_supp ? 32'hF : nib(m_act, dg));
            chk("m_digit_en", digit_en, (m_run && m_p % P >= B && !m_supp) ? (1 << dg) : 0);
            chk("m_frame_done", frame_done, m_run && m_p == FRAME - 1);
            chk("m_load_ready", load_ready, !m_pend);
            chk("m_invalid_err", invalid_err, m_inv);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load(input logic [4*N-1:0] v);
        @(negedge clk);
        load_valid = 1'b1;
        load_value = v;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_timeout", frame_done, 1);
    endtask

    task automatic scan_or(input int cycles, output logic [N-1:0] den_or, output int fd_n);
        den_or = '0;
        fd_n = 0;
        for (int k = 0; k < cycles; k++) begin
            den_or |= digit_en;
            fd_n += int'(frame_done);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [N-1:0] den_or;
        int fd_n, n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_bcd", bcd, 0);
        chk("rst_digit_en", digit_en, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_invalid_err", invalid_err, 0);
        reset = 1'b1;
        scan_or(50, den_or, fd_n);
        chk("idle_den_or", den_or, 0);
        chk("idle_fd_count", fd_n, 0);

        load(16'h1234);
        chk("s2_bcd_d0", bcd, 4);
        chk("s2_dark_d0", digit_en, 0);
        repeat (2) @(negedge clk);
        chk("s2_en_d0", digit_en, 4'b0001);
        repeat (8) @(negedge clk);
        chk("s2_bcd_d1", bcd, 3);
        chk("s2_dark_d1", digit_en, 0);
        repeat (2) @(negedge clk);
        chk("s2_en_d1", digit_en, 4'b0010);
        repeat (10) @(negedge clk);
        chk("s2_en_d2", digit_en, 4'b0100);
        chk("s2_bcd_d2", bcd, 2);
        repeat (10) @(negedge clk);
        chk("s2_en_d3", digit_en, 4'b1000);
        chk("s2_bcd_d3", bcd, 1);
        repeat (7) @(negedge clk);
        chk("s2_frame_done", frame_done, 1);
        @(negedge clk);
        chk("s2_wrap_bcd", bcd, 4);
        chk("s2_wrap_dark", digit_en, 0);
        scan_or(80, den_or, fd_n);
        chk("s2_fd_count", fd_n, 2);

        do_reset();
        lz_blank_en = 1'b1;
        load(16'h0007);
        scan_or(80, den_or, fd_n);
        chk("s3_only_d0", den_or, 4'b0001);
        chk("s3_fd_count", fd_n, 2);

        do_reset();
        load(16'h0000);
        chk("s4_bcd_d0", bcd, 0);
        repeat (10) @(negedge clk);
        chk("s4_bcd_d1_blank", bcd, 4'hF);
        scan_or(40, den_or, fd_n);
        chk("s4_only_d0", den_or, 4'b0001);

        do_reset();
        lz_blank_en = 1'b0;
        load(16'h1234);
        repeat (14) @(negedge clk);
        load_valid = 1'b1;
        load_value = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        chk("s5_ready_low", load_ready, 0);
        load_value = 16'h9999;
        repeat (10) @(negedge clk);
        load_valid = 1'b0;
        chk("s5_still_low", load_ready, 0);
        wait_fd();
        chk("s5_old_bcd", bcd, 1);
        @(negedge clk);
        chk("s5_new_bcd", bcd, 8);
        chk("s5_ready_back", load_ready, 1);

        do_reset();
        load(16'h12A4);
        chk("s6_inv_set", invalid_err, 1);
        chk("s6_bcd_d0", bcd, 4);
        repeat (10) @(negedge clk);
        chk("s6_bcd_d1_blank", bcd, 4'hF);
        repeat (2) @(negedge clk);
        chk("s6_d1_dark", digit_en, 0);
        load(16'h1234);
        chk("s6_ready_low", load_ready, 0);
        wait_fd();
        chk("s6_inv_held", invalid_err, 1);
        @(negedge clk);
        chk("s6_inv_clear", invalid_err, 0);
        chk("s6_new_bcd", bcd, 4);
        n = 0;
        while (digit_en == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s6_in_drive", digit_en != '0, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("s6_rst_bcd", bcd, 0);
        chk("s6_rst_den", digit_en, 0);
        chk("s6_rst_ready", load_ready, 1);
        chk("s6_rst_fd", frame_done, 0);
        chk("s6_rst_inv", invalid_err, 0);
        reset = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            load_valid = $urandom_range(0, 7) == 0;
            load_value = rand_val();
            if ($urandom_range(0, 63) == 0) lz_blank_en = ~lz_blank_en;
            reset = $urandom_range(0, 399) != 0;
        end
        @(negedge clk);
        reset = 1'b1;
        load_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display. It shares one `bcd_to_7seg` decoder across `NUM_DIGITS` digits. It accepts a packed BCD value through a valid/ready load port and drives the decoder's `bcd` input one digit at a time, with a one-hot digit enable. Between digits it inserts blanking intervals, which hide the decoder's one-cycle registered latency and prevent ghosting. It sits between the value-producing logic and the display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; range 2–8.
- `DWELL_CYCLES`, 1000: cycles each digit is lit; must be ≥1.
- `BLANK_CYCLES`, 16: dark cycles before each digit; must be ≥2, to cover the decoder latency.
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `load_valid` in 1: a new display value is offered.
- `load_ready` out 1: the controller can accept a value.
- `load_value` in 4*NUM_DIGITS: packed BCD; nibble 0 is the least-significant digit.
- `lz_blank_en` in 1: enables leading-zero suppression.
- `bcd` out 4: drives the shared decoder's `bcd` input.
- `digit_en` out NUM_DIGITS: one-hot digit select, active-high; bit i selects digit i.
- `frame_done` out 1: one-cycle pulse at the end of each full scan.
- `invalid_err` out 1: sticky flag; the active value contains a nibble greater than 9.

## Operation
- Registers:
  - `active`: the value being displayed.
  - `shadow` plus a `pending` flag: a value accepted but not yet applied.
  - Digit index `idx`.
  - Down-counter `cnt`.
  - State.
- States:
  - IDLE: entered after reset; no value has been loaded yet. `digit_en`=0.
  - BLANK: `digit_en`=0 for BLANK_CYCLES.
  - DRIVE: `digit_en`=one-hot(`idx`) for DWELL_CYCLES.
- Transitions:
  - IDLE→BLANK when the first load is accepted. The value goes directly to `active` and `idx`=0.
  - BLANK→DRIVE when `cnt` expires.
  - DRIVE→BLANK with `idx`+1 when `cnt` expires.
  - After `idx`=NUM_DIGITS-1, `idx` wraps to 0. This is the frame boundary.
- `bcd` is updated to nibble `idx` of `active` on the first BLANK cycle of each digit and held through DRIVE.
- Digit suppression: if the digit is suppressed, `bcd`=4'hF (decoder outputs 0) and `digit_en` stays 0 through DRIVE. The time slot is still consumed, so the scan rate stays constant. A digit is suppressed when either:
  - it is an invalid nibble (>9), or
  - leading-zero rule: `lz_blank_en`=1, i≠0, and all nibbles i..NUM_DIGITS-1 are 0.
- Load handshake:
  - `load_ready` = !`pending`.
  - A transfer occurs when `load_valid` && `load_ready`.
  - In non-IDLE states the transferred value goes to `shadow` and `pending` is set.
  - At a frame boundary, `shadow` is copied to `active` and `pending` is cleared.
  - A transfer in the same cycle as a frame boundary bypasses `shadow` and goes directly to `active`.
- `invalid_err` is recomputed whenever `active` is updated, and is held between updates.
- Reset in any state returns everything to reset values. A partially scanned frame is abandoned, and the pending value is discarded.

## Timing
- Reset values:
  - `bcd`=0.
  - `digit_en`=0.
  - `load_ready`=1.
  - `frame_done`=0.
  - `invalid_err`=0.
  - State IDLE, `pending`=0.
- First digit: the load transfer occurs at cycle T. Then:
  - `bcd` is valid at T+1.
  - `digit_en[0]` rises at T+1+BLANK_CYCLES.
- Per-digit period is BLANK_CYCLES+DWELL_CYCLES. Frame period is NUM_DIGITS×(BLANK_CYCLES+DWELL_CYCLES).
- `bcd` always changes at least BLANK_CYCLES (≥2) cycles before `digit_en` rises. The decoder output is therefore stable while its digit is lit.
- `frame_done` is high during the last DRIVE cycle of digit NUM_DIGITS-1.
- A shadowed value first appears on `bcd` on the cycle after `frame_done`.
- `load_ready` falls the cycle after a shadow transfer. It rises the cycle after the frame boundary.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `seven_seg_pkg` holds:
  - the state encoding (IDLE/BLANK/DRIVE),
  - `BCD_BLANK`=4'hF,
  - `BCD_MAX`=9.
- Optional sub-module `scan_timer`: loadable down-counter with an expire flag, sized $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).
- The `bcd_to_7seg` decoder is instantiated outside this block, alongside it.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
- Reset then idle for 50 cycles → `digit_en`=0, `bcd`=0, `load_ready`=1, `frame_done` never pulses.
- Load 16'h1234 with `lz_blank_en`=0 → `bcd` sequence 4,3,2,1. `digit_en` sequence 0001,0010,0100,1000, each high for 8 cycles after 2 dark cycles. `frame_done` every 40 cycles. Checker compares the decoder output against the expected patterns while each digit is lit.
- Load 16'h0007 with `lz_blank_en`=1 → only `digit_en[0]` is ever asserted. Digits 1–3 stay dark, and the frame period remains 40 cycles.
- Load 16'h0000 with `lz_blank_en`=1 → digit 0 shows 0; digits 1–3 stay dark.
- Mid-frame load of 16'h5678 after 16'h1234 → `load_ready` goes low. A second `load_valid` is not accepted. 5678 appears starting with the frame after the next `frame_done`, and `load_ready` returns to 1.
- Load 16'h12A4 → `invalid_err`=1 and digit 1 is dark. Then load 16'h1234 → `invalid_err`=0 after the boundary. Reset asserted mid-DRIVE → all outputs return to reset values on the next edge.
